// File: rtl/zepto_pkg.sv
// zepto_pkg: definitions shared by the instruction-fetch stage.
//   DATA_W / ADDR_W : default instruction word and PC widths
//   estado_t        : fetch FSM states (OCIOSO, REQ, ENTREGA)
//   PC_INC          : step added to the PC when an instruction is consumed
package zepto_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;

    localparam logic [ADDR_W-1:0] PC_INC = 1;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        REQ     = 2'd1,
        ENTREGA = 2'd2
    } estado_t;

endpackage

// File: rtl/busca_instrucao_if.sv
// busca_instrucao_if: bus bundle around the fetch stage.
//   PC side      : pc_atual (PC reg output), pc_prox (PC reg data input)
//   memory side  : mem_addr, mem_req -> ; mem_ack, mem_rdata <-
//   decoder side : instr, instr_valid -> ; instr_ready <-
//   redirect     : desvio, desvio_alvo <-
// master = fetch stage, slave = environment (PC reg, memory, decoder).
interface busca_instrucao_if;
    import zepto_pkg::*;

    logic [ADDR_W-1:0] pc_atual;
    logic [ADDR_W-1:0] pc_prox;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_req;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic              instr_ready;
    logic              desvio;
    logic [ADDR_W-1:0] desvio_alvo;

    modport master (
        input  pc_atual, mem_ack, mem_rdata, instr_ready, desvio, desvio_alvo,
        output pc_prox, mem_addr, mem_req, instr, instr_valid
    );

    modport slave (
        output pc_atual, mem_ack, mem_rdata, instr_ready, desvio, desvio_alvo,
        input  pc_prox, mem_addr, mem_req, instr, instr_valid
    );

endinterface

// File: rtl/busca_instrucao.sv
// busca_instrucao: instruction-fetch stage between the PC register and decoder.
//   i_clk : system clock, rising edge
//   i_rst : asynchronous active-high reset
//   bus   : busca_instrucao_if.master (PC, memory req/ack, decoder valid/ready,
//           redirect)
// The PC register loads pc_prox every clock, so pc_prox must echo pc_atual
// whenever fetch is not advancing or redirecting.
module busca_instrucao
    import zepto_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    busca_instrucao_if.master  bus
);

    estado_t           r_estado;
    logic [DATA_W-1:0] r_instr;

    logic              w_req;
    logic              w_valid;
    logic              w_handshake;
    logic              w_ack_ok;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_pc_prox;

    // A redirect kills both handshakes in the cycle it is asserted.
    assign w_req       = (r_estado == REQ)     & ~bus.desvio;
    assign w_valid     = (r_estado == ENTREGA) & ~bus.desvio;
    assign w_handshake = w_valid & bus.instr_ready;
    assign w_ack_ok    = w_req & bus.mem_ack;

    // Natural ADDR_W-bit wrap: 0xFFFF + 1 -> 0x0000.
    assign w_pc_inc = bus.pc_atual + PC_INC;

    always_comb begin
        w_pc_prox = bus.pc_atual;
        if (bus.desvio)
            w_pc_prox = bus.desvio_alvo;
        else if (w_handshake)
            w_pc_prox = w_pc_inc;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_estado <= OCIOSO;
            r_instr  <= '0;
        end else if (bus.desvio) begin
            // Any ack in this cycle is dropped; refetch from the new target.
            r_estado <= REQ;
        end else begin
            case (r_estado)
                OCIOSO:  r_estado <= REQ;
                REQ: begin
                    if (w_ack_ok) begin
                        r_instr  <= bus.mem_rdata;
                        r_estado <= ENTREGA;
                    end
                end
                ENTREGA: begin
                    if (w_handshake)
                        r_estado <= REQ;
                end
                default: r_estado <= OCIOSO;
            endcase
        end
    end

    assign bus.mem_req     = w_req;
    assign bus.mem_addr    = bus.pc_atual;
    assign bus.instr       = r_instr;
    assign bus.instr_valid = w_valid;
    assign bus.pc_prox     = w_pc_prox;

endmodule

// File: tb/tb_busca_instrucao.sv
module tb_busca_instrucao;
    import zepto_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    busca_instrucao_if bus ();

    busca_instrucao dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // PC register model: loads pc_prox every clock unless the bench forces it.
    logic              pc_force = 1'b0;
    logic [ADDR_W-1:0] pc_force_val = '0;
    always @(posedge clk) begin
        if (pc_force) bus.pc_atual <= pc_force_val;
        else          bus.pc_atual <= bus.pc_prox;
    end

    int n_chk  = 0;
    int n_fail = 0;
    logic [DATA_W-1:0] sb[$];
    logic [DATA_W-1:0] exp_i;

    // values sampled by cyc()
    logic              s_req, s_valid;
    logic [ADDR_W-1:0] s_addr, s_pcn, s_pc;
    logic [DATA_W-1:0] s_instr;

    // Drive one cycle of stimulus from a negedge, sample combinational outputs,
    // push accepted memory data to the scoreboard, then advance to next negedge.
    task automatic cyc(input logic ack, input logic [DATA_W-1:0] rd,
                       input logic rdy, input logic dv, input logic [ADDR_W-1:0] alvo);
        bus.desvio      = dv;
        bus.desvio_alvo = alvo;
        bus.instr_ready = rdy;
        bus.mem_ack     = ack;
        bus.mem_rdata   = rd;
        #1;
        s_req   = bus.mem_req;
        s_valid = bus.instr_valid;
        s_addr  = bus.mem_addr;
        s_pcn   = bus.pc_prox;
        s_pc    = bus.pc_atual;
        s_instr = bus.instr;
        if (s_req && ack && !dv) sb.push_back(rd);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [ADDR_W-1:0] pc0);
        rst = 1'b1;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0; bus.instr_ready = 1'b0;
        bus.desvio = 1'b0; bus.desvio_alvo = '0;
        pc_force = 1'b1; pc_force_val = pc0;
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        pc_force = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset(16'h0123);
        rst = 1'b1;
        #1;
        n_chk++;
        if (bus.mem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.instr !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_outputs: req=%b valid=%b instr=%h, want 0 0 0000",
                     bus.mem_req, bus.instr_valid, bus.instr);
        end
        n_chk++;
        if (bus.pc_prox !== 16'h0123 || bus.mem_addr !== 16'h0123) begin
            n_fail++;
            $display("FAIL reset_pc: pc_prox=%h mem_addr=%h, want 0123", bus.pc_prox, bus.mem_addr);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        do_reset(16'h0000);
        cyc(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);             // OCIOSO
        n_chk++;
        if (s_req !== 1'b0) begin n_fail++; $display("FAIL basic_ocioso_req: got %b want 0", s_req); end
        cyc(1'b1, 16'h1234, 1'b1, 1'b0, 16'h0);          // REQ, immediate ack
        n_chk++;
        if (s_req !== 1'b1 || s_addr !== 16'h0000) begin
            n_fail++; $display("FAIL basic_req: req=%b addr=%h want 1 0000", s_req, s_addr);
        end
        cyc(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);             // ENTREGA, ready
        exp_i = (sb.size() != 0) ? sb.pop_front() : 16'hxxxx;
        n_chk++;
        if (s_valid !== 1'b1 || s_instr !== exp_i) begin
            n_fail++; $display("FAIL basic_deliver: valid=%b instr=%h want 1 %h", s_valid, s_instr, exp_i);
        end
        n_chk++;
        if (s_pcn !== 16'h0001) begin n_fail++; $display("FAIL basic_pcnext: got %h want 0001", s_pcn); end
        cyc(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
        n_chk++;
        if (s_req !== 1'b1 || s_addr !== 16'h0001) begin
            n_fail++; $display("FAIL basic_next_req: req=%b addr=%h want 1 0001", s_req, s_addr);
        end
    endtask

    task automatic test_backpressure;
        do_reset(16'h0020);
        cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        cyc(1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
            n_chk++;
            if (s_valid !== 1'b1 || s_instr !== sb[0] || s_req !== 1'b0 || s_pcn !== 16'h0020) begin
                n_fail++;
                $display("FAIL bp_stall%0d: valid=%b instr=%h req=%b pc_prox=%h want 1 %h 0 0020",
                         i, s_valid, s_instr, s_req, s_pcn, sb[0]);
            end
        end
        cyc(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
        exp_i = (sb.size() != 0) ? sb.pop_front() : 16'hxxxx;
        n_chk++;
        if (s_valid !== 1'b1 || s_instr !== exp_i || s_pcn !== 16'h0021) begin
            n_fail++; $display("FAIL bp_release: valid=%b instr=%h pc_prox=%h want 1 %h 0021",
                               s_valid, s_instr, s_pcn, exp_i);
        end
    endtask

    task automatic test_waitstates;
        do_reset(16'h0010);
        cyc(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
            n_chk++;
            if (s_req !== 1'b1 || s_addr !== 16'h0010 || s_valid !== 1'b0 || s_pcn !== 16'h0010) begin
                n_fail++; $display("FAIL ws_wait%0d: req=%b addr=%h valid=%b pc_prox=%h want 1 0010 0 0010",
                                   i, s_req, s_addr, s_valid, s_pcn);
            end
        end
        cyc(1'b1, 16'hA5A5, 1'b1, 1'b0, 16'h0);
        n_chk++;
        if (s_req !== 1'b1 || s_addr !== 16'h0010) begin
            n_fail++; $display("FAIL ws_ack: req=%b addr=%h want 1 0010", s_req, s_addr);
        end
        cyc(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
        exp_i = (sb.size() != 0) ? sb.pop_front() : 16'hxxxx;
        n_chk++;
        if (s_valid !== 1'b1 || s_instr !== exp_i) begin
            n_fail++; $display("FAIL ws_deliver: valid=%b instr=%h want 1 %h", s_valid, s_instr, exp_i);
        end
    endtask

    task automatic test_redirect;
        do_reset(16'h0030);
        cyc(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
        cyc(1'b1, 16'h1111, 1'b1, 1'b0, 16'h0);
        // redirect in ENTREGA with ready
        cyc(1'b0, 16'h0, 1'b1, 1'b1, 16'h0040);
        if (sb.size() != 0) void'(sb.pop_front());   // killed, never delivered
        n_chk++;
        if (s_valid !== 1'b0 || s_req !== 1'b0 || s_pcn !== 16'h0040) begin
            n_fail++; $display("FAIL redir_entrega: valid=%b req=%b pc_prox=%h want 0 0 0040",
                               s_valid, s_req, s_pcn);
        end
        // redirect in REQ with coincident ack
        cyc(1'b1, 16'h2222, 1'b1, 1'b1, 16'h0040);
        n_chk++;
        if (s_valid !== 1'b0 || s_req !== 1'b0 || s_pcn !== 16'h0040) begin
            n_fail++; $display("FAIL redir_req: valid=%b req=%b pc_prox=%h want 0 0 0040",
                               s_valid, s_req, s_pcn);
        end
        cyc(1'b1, 16'h3333, 1'b1, 1'b0, 16'h0);
        n_chk++;
        if (s_req !== 1'b1 || s_addr !== 16'h0040 || s_valid !== 1'b0) begin
            n_fail++; $display("FAIL redir_refetch: req=%b addr=%h valid=%b want 1 0040 0",
                               s_req, s_addr, s_valid);
        end
        cyc(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
        exp_i = (sb.size() != 0) ? sb.pop_front() : 16'hxxxx;
        n_chk++;
        if (s_valid !== 1'b1 || s_instr !== exp_i) begin
            n_fail++; $display("FAIL redir_ack_dropped: valid=%b instr=%h want 1 %h", s_valid, s_instr, exp_i);
        end
    endtask

    task automatic test_wrap;
        do_reset(16'hFFFF);
        cyc(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
        cyc(1'b1, 16'h5A5A, 1'b1, 1'b0, 16'h0);
        cyc(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
        exp_i = (sb.size() != 0) ? sb.pop_front() : 16'hxxxx;
        n_chk++;
        if (s_valid !== 1'b1 || s_instr !== exp_i || s_pcn !== 16'h0000) begin
            n_fail++; $display("FAIL wrap_pcnext: valid=%b instr=%h pc_prox=%h want 1 %h 0000",
                               s_valid, s_instr, s_pcn, exp_i);
        end
        cyc(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
        n_chk++;
        if (s_req !== 1'b1 || s_addr !== 16'h0000) begin
            n_fail++; $display("FAIL wrap_next_req: req=%b addr=%h want 1 0000", s_req, s_addr);
        end
    endtask

    task automatic test_async_reset;
        do_reset(16'h0050);
        cyc(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
        cyc(1'b1, 16'h7777, 1'b1, 1'b0, 16'h0);
        cyc(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);     // delivers 0x7777, back to REQ
        if (sb.size() != 0) void'(sb.pop_front());
        bus.mem_ack = 1'b0; bus.instr_ready = 1'b0;
        #1;
        n_chk++;
        if (bus.mem_req !== 1'b1 || bus.instr !== 16'h7777) begin
            n_fail++; $display("FAIL areset_pre: req=%b instr=%h want 1 7777", bus.mem_req, bus.instr);
        end
        rst = 1'b1;                               // between edges
        #1;
        n_chk++;
        if (bus.mem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.instr !== 16'h0000) begin
            n_fail++; $display("FAIL areset_immediate: req=%b valid=%b instr=%h want 0 0 0000",
                               bus.mem_req, bus.instr_valid, bus.instr);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
        n_chk++;
        if (s_req !== 1'b0 || s_valid !== 1'b0) begin
            n_fail++; $display("FAIL areset_ocioso: req=%b valid=%b want 0 0", s_req, s_valid);
        end
        cyc(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
        n_chk++;
        if (s_req !== 1'b1) begin n_fail++; $display("FAIL areset_req: req=%b want 1", s_req); end
    endtask

    initial begin
        bus.mem_ack = 1'b0; bus.mem_rdata = '0; bus.instr_ready = 1'b0;
        bus.desvio = 1'b0; bus.desvio_alvo = '0;
        @(negedge clk);
        test_reset;
        test_basic;
        test_backpressure;
        test_waitstates;
        test_redirect;
        test_wrap;
        test_async_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
